// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Holds the FSM state encoding and hold-counter sizing used by the top.
package arb_pkg;

  localparam int N            = 8;
  localparam int IDX_W        = 3;
  localparam int HOLD_W       = 8;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin selector: rotate requests so ptr is at bit 0,
// take the lowest set bit, then rotate the one-hot choice back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [N-1:0]     sel_rot;
  logic [IDX_W-1:0] first_idx;

  // Index arithmetic is 3 bits wide, so additions and subtractions wrap mod 8.
  for (genvar gi = 0; gi < N; gi++) begin : g_rotate
    assign rot[gi] = req[IDX_W'(gi) + ptr];
  end

  always_comb begin
    first_idx = '0;
    sel_rot   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first_idx = IDX_W'(i);
      end
    end
    if (|rot) begin
      sel_rot[first_idx] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_unrotate
    assign pick[gi] = sel_rot[IDX_W'(gi) - ptr];
  end

  assign winner = first_idx + ptr;
  assign any    = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, owner release, and a
// hold-time limit that revokes the grant with a one-cycle timeout pulse.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout
);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  owner_reg, owner_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [N-1:0]      grant_reg, grant_next;
  logic              busy_reg, busy_next;
  logic              timeout_reg, timeout_next;

  logic [N-1:0]      pick;
  logic [IDX_W-1:0]  winner;
  logic              any;
  logic              end_release;
  logic              end_drop;
  logic              end_limit;
  logic              end_any;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .pick   (pick),
    .winner (winner),
    .any    (any)
  );

  assign end_release = rel;
  assign end_drop    = ~req[owner_reg];
  assign end_limit   = (hold_reg == HOLD_W'(MAX_HOLD - 1));
  assign end_any     = end_release | end_drop | end_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      owner_reg   <= '0;
      hold_reg    <= '0;
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      owner_reg   <= owner_next;
      hold_reg    <= hold_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any) state_next = GRANT;
      GRANT:   if (end_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Leaving GRANT always passes through IDLE, which forces an all-zero
  // grant cycle between any two consecutive grants.
  always_comb begin
    ptr_next     = ptr_reg;
    owner_next   = owner_reg;
    hold_next    = hold_reg;
    grant_next   = '0;
    busy_next    = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any) begin
          grant_next = pick;
          busy_next  = 1'b1;
          owner_next = winner;
          ptr_next   = winner + IDX_W'(1);
          hold_next  = '0;
        end
      end
      GRANT: begin
        hold_next = (hold_reg == '1) ? hold_reg : hold_reg + HOLD_W'(1);
        if (end_any) begin
          timeout_next = end_limit & ~end_release & ~end_drop;
        end else begin
          grant_next = grant_reg;
          busy_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): reset, single request,
// rotation, fairness, timeout, release at the limit and owner drop.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %-16s observed %02h expected %02h ok", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input logic t);
    check({tag, ".grant"}, grant, g);
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, (g != 8'h00)});
    check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    rel = 1'b0;
    step();
    step();
    check_out("reset", 8'h00, 1'b0);
    rst = 1'b0;
    step();
    check_out("idle", 8'h00, 1'b0);

    // Single request: requester 4, then release.
    req = 8'h10;
    step();
    check_out("single", 8'h10, 1'b0);
    rel = 1'b1;
    step();
    check_out("single_rel", 8'h00, 1'b0);
    rel = 1'b0;
    req = 8'h00;
    step();

    // ptr is now 5; asynchronous reset while granting requester 5.
    req = 8'hFF;
    step();
    check_out("pre_reset", 8'h20, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_out("rot0", 8'h01, 1'b0);

    // Rotation with release each grant, wrapping back to requester 0.
    for (int i = 0; i < 8; i++) begin
      rel = 1'b1;
      step();
      check_out("rot_gap", 8'h00, 1'b0);
      rel = 1'b0;
      step();
      check_out("rot", 8'h01 << ((i + 1) % 8), 1'b0);
    end
    rel = 1'b1;
    step();
    check_out("rot_end", 8'h00, 1'b0);
    rel = 1'b0;
    req = 8'h00;
    step();

    // Bring ptr to 6 by serving requester 5, then req=05.
    req = 8'h20;
    step();
    check_out("to_ptr6", 8'h20, 1'b0);
    rel = 1'b1;
    step();
    rel = 1'b0;
    req = 8'h05;
    check_out("to_ptr6_rel", 8'h00, 1'b0);
    step();
    check_out("fair_first", 8'h01, 1'b0);
    rel = 1'b1;
    step();
    check_out("fair_gap", 8'h00, 1'b0);
    rel = 1'b0;
    step();
    check_out("fair_second", 8'h04, 1'b0);
    rel = 1'b1;
    step();
    rel = 1'b0;
    req = 8'h00;
    step();

    // Timeout after 4 cycles of holding requester 3.
    req = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_out("hold", 8'h08, 1'b0);
    end
    step();
    check_out("timeout", 8'h00, 1'b1);
    step();
    check_out("regrant", 8'h08, 1'b0);
    step();
    step();
    step();
    check_out("hold4", 8'h08, 1'b0);
    rel = 1'b1;
    step();
    check_out("rel_at_limit", 8'h00, 1'b0);
    rel = 1'b0;
    req = 8'h00;
    step();

    // ptr=4: serve requester 1, other req changes ignored, then owner drop.
    req = 8'h02;
    step();
    check_out("own", 8'h02, 1'b0);
    req = 8'hFE;
    step();
    check_out("others_ignored", 8'h02, 1'b0);
    req = 8'hFD;
    step();
    check_out("owner_drop", 8'h00, 1'b0);
    req = 8'h00;
    rel = 1'b1;
    step();
    check_out("idle_rel", 8'h00, 1'b0);
    rel = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
